sprite_draw_scheduler: RTL

//  Arbitrates tile-redraw requests from two game-logic requesters (A = player/box mover, B = level loader),

---
 rtl/sprite_draw_scheduler_pkg.sv | 30 +++
 rtl/sprite_draw_scheduler_if.sv | 39 +++
 rtl/sprite_draw_scheduler_fifo.sv | 54 +++++
 rtl/sprite_draw_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared definitions for the sprite draw scheduler: screen geometry in
// tiles, request record layout, sequencer state encoding and range check.
package sprite_draw_scheduler_pkg;

    localparam int TILE_COLS = 20;
    localparam int TILE_ROWS = 15;
    localparam int SPRITE_W  = 8;
    localparam int PIX_SHIFT = $clog2(SPRITE_W);
    localparam int ID_W      = 4;
    localparam int COL_W     = 5;
    localparam int ROW_W     = 4;
    localparam int REQ_W     = COL_W + ROW_W + ID_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [ID_W-1:0]  id;
    } tile_req_t;

    function automatic logic tile_in_range(input tile_req_t r);
        return (r.col < COL_W'(TILE_COLS)) && (r.row < ROW_W'(TILE_ROWS));
    endfunction

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Request and draw-side signal bundle of the sprite draw scheduler.
// master = game logic / test side, slave = the scheduler itself.
interface sprite_draw_scheduler_if;
    import sprite_draw_scheduler_pkg::*;

    logic             a_valid;
    logic [COL_W-1:0] a_col;
    logic [ROW_W-1:0] a_row;
    logic [ID_W-1:0]  a_id;
    logic             a_ready;

    logic             b_valid;
    logic [COL_W-1:0] b_col;
    logic [ROW_W-1:0] b_row;
    logic [ID_W-1:0]  b_id;
    logic             b_ready;

    logic [7:0]       draw_x;
    logic [6:0]       draw_y;
    logic [ID_W-1:0]  draw_id;
    logic             begin_draw;
    logic             busy;
    logic             range_err;

    modport master (
        output a_valid, a_col, a_row, a_id,
        output b_valid, b_col, b_row, b_id,
        input  a_ready, b_ready,
        input  draw_x, draw_y, draw_id, begin_draw, busy, range_err
    );

    modport slave (
        input  a_valid, a_col, a_row, a_id,
        input  b_valid, b_col, b_row, b_id,
        output a_ready, b_ready,
        output draw_x, draw_y, draw_id, begin_draw, busy, range_err
    );

endinterface

// File: rtl/sprite_draw_scheduler_fifo.sv
// Synchronous request FIFO: registered count, head is the combinational
// read of the oldest entry. Push and pop are ignored when full / empty.
module sprite_draw_scheduler_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != C_FULL);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Sprite draw scheduler: round-robin arbiter for two tile-redraw requesters,
// range check, request FIFO and the sequencer that feeds sprite_draw one
// 8x8 sprite at a time.
// Optional full-screen sweep is enabled by defining SCHED_SWEEP_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting; pops FIFO head (or next sweep tile) into draw regs
// ST_ISSUE | begin_draw high for this single cycle
// ST_HOLD  | draw inputs held stable while sprite_draw plots its pixels
module sprite_draw_scheduler
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int DRAW_CYCLES = 66
) (
    input  logic            i_clk,
    input  logic            i_resetn,
`ifdef SCHED_SWEEP_EN
    input  logic            i_sweep_start,
    input  logic [ID_W-1:0] i_sweep_id,
    output logic            o_sweep_busy,
`endif
    sprite_draw_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(DRAW_CYCLES);
    localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);
    localparam logic [HW-1:0] C_HOLD_LOAD = HW'(DRAW_CYCLES - 1);

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_rr_b;
    logic            r_range_err;
    logic [7:0]      r_draw_x;
    logic [6:0]      r_draw_y;
    logic [ID_W-1:0] r_draw_id;

    tile_req_t       w_req_a;
    tile_req_t       w_req_b;
    tile_req_t       w_req_sel;
    tile_req_t       w_head;
    logic [CW-1:0]   w_count;
    logic            w_has_room;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_req_ok;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_sweep_busy;

    assign w_req_a    = {bus.a_col, bus.a_row, bus.a_id};
    assign w_req_b    = {bus.b_col, bus.b_row, bus.b_id};

    // Grant uses the registered count only: a pop in the same cycle does not
    // open a slot early.
    assign w_has_room = (w_count < C_FULL);
    assign w_grant_a  = bus.a_valid && w_has_room && (!bus.b_valid || !r_rr_b);
    assign w_grant_b  = bus.b_valid && w_has_room && (!bus.a_valid ||  r_rr_b);
    assign w_req_sel  = w_grant_b ? w_req_b : w_req_a;
    assign w_req_ok   = tile_in_range(w_req_sel);
    assign w_push     = (w_grant_a || w_grant_b) && w_req_ok;
    assign w_drop     = (w_grant_a || w_grant_b) && !w_req_ok;

    sprite_draw_scheduler_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_push   (w_push),
        .i_wdata  (w_req_sel),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count)
    );

    // Round-robin pointer moves to the loser only when both requested.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_rr_b      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_range_err <= w_drop;
            if (w_grant_a && bus.b_valid) begin
                r_rr_b <= 1'b1;
            end else if (w_grant_b && bus.a_valid) begin
                r_rr_b <= 1'b0;
            end
        end
    end

`ifdef SCHED_SWEEP_EN
    logic             r_sw_busy;
    logic             r_sw_last_issued;
    logic [COL_W-1:0] r_sw_col;
    logic [ROW_W-1:0] r_sw_row;
    logic [ID_W-1:0]  r_sw_id;
    logic             w_sweep_pending;
    logic             w_take_sweep;
    logic             w_hold_done;

    assign w_sweep_pending = r_sw_busy && !r_sw_last_issued;
    assign w_hold_done     = (r_state == ST_HOLD) && (r_hold_cnt == '0);
    assign w_sweep_busy    = r_sw_busy;
    assign o_sweep_busy    = r_sw_busy;

    // Sweep arm, row-major tile walk, and release once the last tile's hold ends.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sw_busy        <= 1'b0;
            r_sw_last_issued <= 1'b0;
            r_sw_col         <= '0;
            r_sw_row         <= '0;
            r_sw_id          <= '0;
        end else if (i_sweep_start && !r_sw_busy) begin
            r_sw_busy        <= 1'b1;
            r_sw_last_issued <= 1'b0;
            r_sw_col         <= '0;
            r_sw_row         <= '0;
            r_sw_id          <= i_sweep_id;
        end else begin
            if (w_take_sweep) begin
                if (r_sw_col == COL_W'(TILE_COLS - 1)) begin
                    r_sw_col <= '0;
                    if (r_sw_row == ROW_W'(TILE_ROWS - 1)) begin
                        r_sw_last_issued <= 1'b1;
                    end else begin
                        r_sw_row <= r_sw_row + 1'b1;
                    end
                end else begin
                    r_sw_col <= r_sw_col + 1'b1;
                end
            end
            if (w_hold_done && r_sw_last_issued) begin
                r_sw_busy        <= 1'b0;
                r_sw_last_issued <= 1'b0;
            end
        end
    end
`else
    assign w_sweep_busy = 1'b0;
`endif

    // Sequencer next-state: a pending sweep outranks the FIFO at IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
`ifdef SCHED_SWEEP_EN
        w_take_sweep = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef SCHED_SWEEP_EN
                if (w_sweep_pending) begin
                    w_take_sweep = 1'b1;
                    w_state_nxt  = ST_ISSUE;
                end else
`endif
                if (w_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (r_hold_cnt == '0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and hold timer (down-count to zero = DRAW_CYCLES in HOLD).
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ISSUE) begin
                r_hold_cnt <= C_HOLD_LOAD;
            end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    // Draw inputs load on selection and stay put until the next selection.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_draw_x  <= '0;
            r_draw_y  <= '0;
            r_draw_id <= '0;
        end else if (w_pop) begin
            r_draw_x  <= {w_head.col, {PIX_SHIFT{1'b0}}};
            r_draw_y  <= {w_head.row, {PIX_SHIFT{1'b0}}};
            r_draw_id <= w_head.id;
        end
`ifdef SCHED_SWEEP_EN
        else if (w_take_sweep) begin
            r_draw_x  <= {r_sw_col, {PIX_SHIFT{1'b0}}};
            r_draw_y  <= {r_sw_row, {PIX_SHIFT{1'b0}}};
            r_draw_id <= r_sw_id;
        end
`endif
    end

    assign bus.a_ready    = w_grant_a;
    assign bus.b_ready    = w_grant_b;
    assign bus.draw_x     = r_draw_x;
    assign bus.draw_y     = r_draw_y;
    assign bus.draw_id    = r_draw_id;
    assign bus.begin_draw = (r_state == ST_ISSUE);
    assign bus.range_err  = r_range_err;
    assign bus.busy       = (w_count != '0) || (r_state != ST_IDLE) || w_sweep_busy;

endmodule
